phase_block_average: RTL and testbench



---
 rtl/phase_block_average.sv | 128 ++++++++++++
 tb/tb_phase_block_average.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_block_average.sv
// Block averager + block-to-block phase-rate estimator for unwrapped 11Q21 phase.
// Optional dphi saturation: define PHASE_BLOCK_AVG_DPHI_SAT_EN (default wraps).
module phase_block_average #(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int M_AXIS_TDATA_WIDTH = 32,
  parameter int DECII_LOG2         = 4
) (
  input  logic                          aclk,
  input  logic                          reset,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                          S_AXIS_tvalid,
  input  logic                          enable,
  output logic [M_AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic [M_AXIS_TDATA_WIDTH-1:0] M_AXIS_dphi_tdata,
  output logic                          M_AXIS_tvalid
);

  localparam int SW = S_AXIS_TDATA_WIDTH;
  localparam int MW = M_AXIS_TDATA_WIDTH;
  localparam int L  = DECII_LOG2;
  localparam int AW = SW + L;
`ifdef PHASE_BLOCK_AVG_DPHI_SAT_EN
  localparam int DW = MW + 1;
`else
  localparam int DW = MW;
`endif

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    RUN
  } state_t;

  state_t               state_q;
  logic signed [AW-1:0] acc_q, acc_d;
  logic        [L-1:0]  cnt_q, cnt_d;
  logic signed [AW-1:0] sum_q;
  logic                 sum_vld_q;
  logic                 first_q;
  logic        [MW-1:0] prev_q;
  logic        [MW-1:0] mean_q;
  logic        [MW-1:0] dphi_q;
  logic                 vld_q;

  logic                 accept;
  logic                 blk_end;
  logic signed [AW-1:0] acc_sum;
  logic        [MW-1:0] mean_w;
  logic signed [DW-1:0] dext;
  logic        [MW-1:0] dphi_w;

  always_comb begin
    accept  = S_AXIS_tvalid && enable;
    blk_end = accept && (cnt_q == '1);
    acc_sum = acc_q + AW'(signed'(S_AXIS_tdata));
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (!enable || blk_end) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Arithmetic shift floors toward -inf; the truncated mean always fits.
  always_comb begin
    mean_w = MW'(sum_q >>> L);
`ifdef PHASE_BLOCK_AVG_DPHI_SAT_EN
    dext = {mean_w[MW-1], mean_w} - {prev_q[MW-1], prev_q};
    if (dext[MW] != dext[MW-1])
      dphi_w = dext[MW] ? {1'b1, {(MW-1){1'b0}}}
                        : {1'b0, {(MW-1){1'b1}}};
    else
      dphi_w = dext[MW-1:0];
`else
    dext   = mean_w - prev_q;
    dphi_w = dext;
`endif
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
      first_q   <= 1'b0;
      prev_q    <= '0;
      mean_q    <= '0;
      dphi_q    <= '0;
      vld_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sum_vld_q <= blk_end;
      vld_q     <= sum_vld_q;
      if (blk_end) begin
        sum_q   <= acc_sum;
        first_q <= (state_q != RUN);
      end
      if (sum_vld_q) begin
        mean_q <= mean_w;
        dphi_q <= first_q ? '0 : dphi_w;
        prev_q <= mean_w;
      end
      // An in-flight block still finishes; leaving IDLE always goes via FIRST.
      if (!enable) begin
        state_q <= IDLE;
        prev_q  <= '0;
      end else begin
        unique case (state_q)
          IDLE:    state_q <= FIRST;
          FIRST:   if (blk_end) state_q <= RUN;
          RUN:     state_q <= RUN;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign M_AXIS_tdata      = mean_q;
  assign M_AXIS_dphi_tdata = dphi_q;
  assign M_AXIS_tvalid     = vld_q;

endmodule

// File: tb/tb_phase_block_average.sv
// Directed bench for phase_block_average at N=4.
// Pulses are captured on the falling edge and checked per scenario.
module tb_phase_block_average;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] S_AXIS_tdata;
  logic         S_AXIS_tvalid;
  logic         enable;
  logic [W-1:0] M_AXIS_tdata;
  logic [W-1:0] M_AXIS_dphi_tdata;
  logic         M_AXIS_tvalid;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W-1:0] q_mean[$];
  logic [W-1:0] q_dphi[$];
  int           q_cyc[$];

  always #5 clk = ~clk;

  phase_block_average #(
    .S_AXIS_TDATA_WIDTH(32),
    .M_AXIS_TDATA_WIDTH(32),
    .DECII_LOG2(2)
  ) dut (
    .aclk(clk),
    .reset(reset),
    .S_AXIS_tdata(S_AXIS_tdata),
    .S_AXIS_tvalid(S_AXIS_tvalid),
    .enable(enable),
    .M_AXIS_tdata(M_AXIS_tdata),
    .M_AXIS_dphi_tdata(M_AXIS_dphi_tdata),
    .M_AXIS_tvalid(M_AXIS_tvalid)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (M_AXIS_tvalid === 1'b1) begin
      q_mean.push_back(M_AXIS_tdata);
      q_dphi.push_back(M_AXIS_dphi_tdata);
      q_cyc.push_back(cyc);
    end
  end

  task automatic drive(input logic [W-1:0] d, input logic v, input logic e);
    S_AXIS_tdata  = d;
    S_AXIS_tvalid = v;
    enable        = e;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (4) drive('0, 1'b0, 1'b1);
    drive('0, 1'b0, 1'b0);
  endtask

  task automatic clear_q();
    q_mean.delete();
    q_dphi.delete();
    q_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) drive(32'h1234_5678, 1'b1, 1'b1);
    n_cmp++;
    if (M_AXIS_tdata !== '0) begin
      n_err++;
      $display("FAIL reset_tdata got %h want 0", M_AXIS_tdata);
    end
    n_cmp++;
    if (M_AXIS_dphi_tdata !== '0) begin
      n_err++;
      $display("FAIL reset_dphi got %h want 0", M_AXIS_dphi_tdata);
    end
    n_cmp++;
    if (M_AXIS_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_tvalid got %b want 0", M_AXIS_tvalid);
    end
    reset = 1'b0;
    drive('0, 1'b0, 1'b0);
  endtask

  task automatic test_constant();
    int t4;
    t4 = 0;
    clear_q();
    for (int i = 0; i < 12; i++) begin
      if (i == 3) t4 = cyc;
      drive(32'h0020_0000, 1'b1, 1'b1);
    end
    repeat (3) drive('0, 1'b0, 1'b1);
    n_cmp++;
    if (q_mean.size() != 3) begin
      n_err++;
      $display("FAIL const_count got %0d want 3", q_mean.size());
    end
    for (int i = 0; i < 3 && i < q_mean.size(); i++) begin
      n_cmp++;
      if (q_mean[i] !== 32'h0020_0000 || q_dphi[i] !== '0) begin
        n_err++;
        $display("FAIL const_pulse%0d got %h/%h want 00200000/0",
                 i, q_mean[i], q_dphi[i]);
      end
    end
    if (q_cyc.size() == 3) begin
      n_cmp++;
      if (q_cyc[0] != t4 + 2) begin
        n_err++;
        $display("FAIL const_latency got %0d want 2", q_cyc[0] - t4);
      end
      n_cmp++;
      if (q_cyc[1] - q_cyc[0] != 4 || q_cyc[2] - q_cyc[1] != 4) begin
        n_err++;
        $display("FAIL const_spacing got %0d,%0d want 4,4",
                 q_cyc[1] - q_cyc[0], q_cyc[2] - q_cyc[1]);
      end
    end
    n_cmp++;
    if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tdata !== 32'h0020_0000) begin
      n_err++;
      $display("FAIL const_hold got %b/%h want 0/00200000",
               M_AXIS_tvalid, M_AXIS_tdata);
    end
    drive('0, 1'b0, 1'b0);
  endtask

  task automatic test_ramp();
    logic [W-1:0] em[3];
    logic [W-1:0] ed[3];
    em = '{32'd1500, 32'd5500, 32'd9500};
    ed = '{32'd0, 32'd4000, 32'd4000};
    clear_q();
    for (int i = 0; i < 12; i++) drive(W'(i * 1000), 1'b1, 1'b1);
    settle();
    n_cmp++;
    if (q_mean.size() != 3) begin
      n_err++;
      $display("FAIL ramp_count got %0d want 3", q_mean.size());
    end
    for (int i = 0; i < 3 && i < q_mean.size(); i++) begin
      n_cmp++;
      if (q_mean[i] !== em[i] || q_dphi[i] !== ed[i]) begin
        n_err++;
        $display("FAIL ramp_pulse%0d got %0d/%0d want %0d/%0d",
                 i, q_mean[i], q_dphi[i], em[i], ed[i]);
      end
    end
  endtask

  task automatic test_floor();
    clear_q();
    drive(32'hFFFF_FFFF, 1'b1, 1'b1);
    repeat (3) drive(32'hFFFF_FFFE, 1'b1, 1'b1);
    settle();
    n_cmp++;
    if (q_mean.size() != 1) begin
      n_err++;
      $display("FAIL floor_count got %0d want 1", q_mean.size());
    end else begin
      n_cmp++;
      if (q_mean[0] !== 32'hFFFF_FFFE || q_dphi[0] !== '0) begin
        n_err++;
        $display("FAIL floor_mean got %h/%h want fffffffe/0",
                 q_mean[0], q_dphi[0]);
      end
    end
  endtask

  task automatic test_gaps();
    clear_q();
    for (int i = 0; i < 8; i++) begin
      drive(32'd5, 1'b1, 1'b1);
      drive(32'd5, 1'b0, 1'b1);
    end
    settle();
    n_cmp++;
    if (q_mean.size() != 2) begin
      n_err++;
      $display("FAIL gaps_count got %0d want 2", q_mean.size());
    end else begin
      n_cmp++;
      if (q_cyc[1] - q_cyc[0] != 8) begin
        n_err++;
        $display("FAIL gaps_spacing got %0d want 8", q_cyc[1] - q_cyc[0]);
      end
      n_cmp++;
      if (q_mean[0] !== 32'd5 || q_mean[1] !== 32'd5 || q_dphi[1] !== '0) begin
        n_err++;
        $display("FAIL gaps_mean got %0d,%0d/%0d want 5,5/0",
                 q_mean[0], q_mean[1], q_dphi[1]);
      end
    end
  endtask

  task automatic test_enable_drop();
    clear_q();
    repeat (4) drive(32'd300, 1'b1, 1'b1);
    repeat (2) drive(32'd999, 1'b1, 1'b1);
    drive(32'd999, 1'b1, 1'b0);
    repeat (4) drive(32'd100, 1'b1, 1'b1);
    settle();
    n_cmp++;
    if (q_mean.size() != 2) begin
      n_err++;
      $display("FAIL endrop_count got %0d want 2", q_mean.size());
    end else begin
      n_cmp++;
      if (q_mean[0] !== 32'd300 || q_mean[1] !== 32'd100 || q_dphi[1] !== '0) begin
        n_err++;
        $display("FAIL endrop_vals got %0d,%0d/%0d want 300,100/0",
                 q_mean[0], q_mean[1], q_dphi[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    repeat (4) drive(32'd300, 1'b1, 1'b1);
    repeat (2) drive(32'd999, 1'b1, 1'b1);
    reset = 1'b1;
    drive(32'd999, 1'b1, 1'b1);
    reset = 1'b0;
    repeat (4) drive(32'd100, 1'b1, 1'b1);
    settle();
    n_cmp++;
    if (q_mean.size() != 2) begin
      n_err++;
      $display("FAIL rstmid_count got %0d want 2", q_mean.size());
    end else begin
      n_cmp++;
      if (q_mean[1] !== 32'd100 || q_dphi[1] !== '0) begin
        n_err++;
        $display("FAIL rstmid_vals got %0d/%0d want 100/0",
                 q_mean[1], q_dphi[1]);
      end
    end
    clear_q();
    repeat (4) drive(32'd50, 1'b1, 1'b1);
    reset = 1'b1;
    drive('0, 1'b0, 1'b1);
    reset = 1'b0;
    settle();
    n_cmp++;
    if (q_mean.size() != 0) begin
      n_err++;
      $display("FAIL rstpipe_count got %0d want 0", q_mean.size());
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_d;
`ifdef PHASE_BLOCK_AVG_DPHI_SAT_EN
    exp_d = 32'h8000_0000;
`else
    exp_d = 32'h0002_0000;
`endif
    clear_q();
    repeat (4) drive(32'h7FFF_0000, 1'b1, 1'b1);
    repeat (4) drive(32'h8001_0000, 1'b1, 1'b1);
    settle();
    n_cmp++;
    if (q_mean.size() != 2) begin
      n_err++;
      $display("FAIL ovf_count got %0d want 2", q_mean.size());
    end else begin
      n_cmp++;
      if (q_mean[0] !== 32'h7FFF_0000 || q_mean[1] !== 32'h8001_0000) begin
        n_err++;
        $display("FAIL ovf_means got %h,%h want 7fff0000,80010000",
                 q_mean[0], q_mean[1]);
      end
      n_cmp++;
      if (q_dphi[0] !== '0 || q_dphi[1] !== exp_d) begin
        n_err++;
        $display("FAIL ovf_dphi got %h,%h want 0,%h",
                 q_dphi[0], q_dphi[1], exp_d);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tdata  = '0;
    test_reset();
    test_constant();
    test_ramp();
    test_floor();
    test_gaps();
    test_enable_drop();
    test_reset_mid();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
